// File: rtl/adr_mismatch_logger_if.sv
// Compare-result input stream and report output stream of the mismatch logger.
// The logger takes the slave side; the compare stage/consumer pair takes the master side.
interface adr_mismatch_logger_if #(
  parameter int unsigned DW = 32
);
  logic          in_valid;
  logic          in_mismatch;
  logic [DW-1:0] in_adr_a;
  logic [DW-1:0] in_adr_b;
  logic          rpt_valid;
  logic          rpt_ready;
  logic [DW-1:0] rpt_adr_a;
  logic [DW-1:0] rpt_adr_b;

  modport master (
    output in_valid, in_mismatch, in_adr_a, in_adr_b, rpt_ready,
    input  rpt_valid, rpt_adr_a, rpt_adr_b
  );

  modport slave (
    input  in_valid, in_mismatch, in_adr_a, in_adr_b, rpt_ready,
    output rpt_valid, rpt_adr_a, rpt_adr_b
  );
endinterface

// File: rtl/adr_mismatch_logger.sv
// Counts address-compare mismatches during test mode, queues mismatching pairs in a
// small FIFO for a valid/ready log consumer, and flags threshold/overflow conditions.
module adr_mismatch_logger #(
  parameter int unsigned DW     = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned THRESH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  adr_mismatch_logger_if.slave bus,
  input  logic                 test_mode,
  input  logic                 clr,
  output logic                 err_flag,
  output logic                 ovf_flag,
  output logic [CNT_W-1:0]     mis_count,
  output logic [CNT_W-1:0]     drop_count,
  output logic                 armed
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] TripAt = CNT_W'(THRESH - 1);

  typedef enum logic [1:0] {StDisarmed, StArmed, StTripped} state_e;

  state_e             state_q, state_d;
  logic [AW:0]        wr_ptr_q, rd_ptr_q;
  logic [2*DW-1:0]    mem_q [DEPTH];
  logic [2*DW-1:0]    head;
  logic               err_q, ovf_q;
  logic [CNT_W-1:0]   mis_q, drop_q;
  logic               empty, full, pop, push, drop, evt, trip;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign evt   = bus.in_valid & bus.in_mismatch & test_mode & (state_q != StDisarmed);
  assign pop   = ~empty & bus.rpt_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts the new record.
  assign push  = evt & (~full | pop);
  assign drop  = evt & full & ~pop;
  assign trip  = evt && (state_q == StArmed) && (mis_q == TripAt);

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = test_mode ? StArmed : StDisarmed;
    end else begin
      unique case (state_q)
        StDisarmed: if (test_mode) state_d = StArmed;
        StArmed: begin
          if (!test_mode) state_d = StDisarmed;
          else if (trip)  state_d = StTripped;
        end
        StTripped: if (!test_mode) state_d = StDisarmed;
        default: state_d = StDisarmed;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StDisarmed;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      mis_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        err_q    <= 1'b0;
        ovf_q    <= 1'b0;
        mis_q    <= '0;
        drop_q   <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        // Sticky: survives test_mode dropping even though the FSM leaves TRIPPED.
        if (trip) err_q <= 1'b1;
        if (drop) ovf_q <= 1'b1;
        if (evt && (mis_q != CntMax))   mis_q  <= mis_q + CNT_W'(1);
        if (drop && (drop_q != CntMax)) drop_q <= drop_q + CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: contents are only visible while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= {bus.in_adr_a, bus.in_adr_b};
  end

  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.rpt_valid = ~empty;
  assign bus.rpt_adr_a = empty ? '0 : head[2*DW-1:DW];
  assign bus.rpt_adr_b = empty ? '0 : head[DW-1:0];

  assign err_flag   = err_q;
  assign ovf_flag   = ovf_q;
  assign mis_count  = mis_q;
  assign drop_count = drop_q;
  assign armed      = (state_q != StDisarmed);

endmodule
